// File: rtl/fpadd_accum_seq.sv
// fpadd_accum_seq: sequencing front end for the multi-cycle fpadd unit.
// It takes a packetised stream of IEEE-754 single-precision words, folds
// each packet into a running sum through fpadd's start/done handshake, and
// returns one result per packet with an element count and a watchdog flag.
// The block does no arithmetic of its own. Special values such as NaN, Inf
// and signed zero pass through exactly as fpadd produces them.
module fpadd_accum_seq #(
  parameter int TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic [15:0] out_count,
  output logic        out_timeout,
  output logic        add_start,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  input  logic        add_done,
  output logic        busy
);

  // The timer must be able to hold TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FIRST,
    S_NEXT,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          to_q, to_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   add_a_q, add_a_d;
  logic [31:0]   add_b_q, add_b_d;

  // State and datapath registers with synchronous reset. A reset in any
  // state, including WAIT, discards the partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FIRST;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      to_q    <= 1'b0;
      timer_q <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      to_q    <= to_d;
      timer_q <= timer_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
    end
  end

  // Next-state and datapath update. The first element of a packet seeds
  // the accumulator directly. Each later element launches one fpadd
  // operation, and add_done is sampled only in WAIT, so a level left high
  // by the previous operation is never seen in ISSUE. The operand
  // registers load only when NEXT accepts an element, so they stay stable
  // from ISSUE through the end of WAIT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    to_d    = to_q;
    timer_d = timer_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;

    case (state_q)
      S_FIRST: begin
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = 16'd1;
          state_d = in_last ? S_OUT : S_NEXT;
        end
      end

      S_NEXT: begin
        if (in_valid) begin
          add_a_d = acc_q;
          add_b_d = in_data;
          last_d  = in_last;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (add_done) begin
          acc_d   = add_sum;
          state_d = last_q ? S_OUT : S_NEXT;
        end else if (timer_q == TIMER_LAST) begin
          // Abandon this add. The accumulator keeps its old value, and a
          // late done is ignored because the next ISSUE restarts fpadd.
          to_d    = 1'b1;
          state_d = last_q ? S_OUT : S_NEXT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_OUT: begin
        if (out_ready) begin
          cnt_d   = '0;
          to_d    = 1'b0;
          state_d = S_FIRST;
        end
      end

      default: begin
        state_d = S_FIRST;
      end
    endcase
  end

  // Outputs depend only on registered state, so there is no combinational
  // path from in_valid or out_ready to any output.
  always_comb begin
    in_ready    = (state_q == S_FIRST) || (state_q == S_NEXT);
    out_valid   = (state_q == S_OUT);
    add_start   = (state_q == S_ISSUE);
    busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                  (state_q == S_OUT);
    out_sum     = acc_q;
    out_count   = cnt_q;
    out_timeout = to_q;
    add_a       = add_a_q;
    add_b       = add_b_q;
  end

endmodule

// File: doc/fpadd_accum_seq.md
# fpadd_accum_seq

Sequencing front end for the team's multi-cycle single-precision adder `fpadd`. It accepts a packetised stream of IEEE-754 words over a valid/ready handshake and drives `fpadd` through its start/done handshake to reduce each packet to a running sum. It returns one result per packet with an element count and a watchdog flag. It sits between the operand source and one `fpadd` instance, and both share `clk` and `reset`.

## Interface
- `TIMEOUT`, default 512: cycles to wait for `add_done` before abandoning an add. This covers the worst-case `fpadd` latency of roughly 290 cycles.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high; clock `clk`.
- `in_valid` input 1: input element valid.
- `in_ready` output 1: element accepted when `in_valid && in_ready`.
- `in_data` input 32: IEEE-754 single-precision element.
- `in_last` input 1: marks the final element of a packet.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready`.
- `out_sum` output 32: packet sum.
- `out_count` output 16: number of elements in the packet. Saturates at 65535.
- `out_timeout` output 1: at least one add in this packet timed out.
- `add_start` output 1: one-cycle start pulse to `fpadd`.
- `add_a`, `add_b` output 32: operands to `fpadd`.
- `add_sum` input 32: `fpadd` result.
- `add_done` input 1: `fpadd` done. Level signal that stays high until the next start.
- `busy` output 1: high in ISSUE, WAIT and OUT.

## Operation
- **State machine states:** FIRST, NEXT, ISSUE, WAIT, OUT.
- **Registered state:** `acc[31:0]`, `cnt[15:0]`, `last_q`, `to_q`, `timer`.
- **Reset:** state becomes FIRST. `acc`, `cnt`, `add_a`, `add_b`, `to_q` and `timer` become 0. Outputs then read `add_start=0`, `out_valid=0`, `out_sum=0`, `out_count=0`, `out_timeout=0`, `busy=0`, `in_ready=1`.
- **FIRST:** `in_ready=1`. On accept, `acc<=in_data` and `cnt<=1`, with no add performed. Go to OUT if `in_last`, otherwise go to NEXT.
- **NEXT:** `in_ready=1`. On accept:
  - `add_a<=acc`, `add_b<=in_data`.
  - `last_q<=in_last`.
  - `cnt<=cnt+1`, saturating.
  - Go to ISSUE.
- **ISSUE:** `add_start=1` for exactly this cycle, `timer<=0`, go to WAIT.
- **WAIT:**
  - If `add_done`: `acc<=add_sum`, then go to OUT if `last_q`, otherwise go to NEXT.
  - Else if `timer==TIMEOUT-1`: `to_q<=1`, `acc` keeps its old value, then take the same `last_q` branch.
  - Else: `timer<=timer+1`.
- **OUT:** `out_valid=1`, `out_sum=acc`, `out_count=cnt`, `out_timeout=to_q`. On `out_ready`, `cnt<=0` and `to_q<=0`, then go to FIRST.
- **Operand stability:** `add_a` and `add_b` are registers and stay stable from ISSUE through the end of WAIT.
- **No arithmetic in this block:** special values (NaN/Inf/zero) pass through exactly as `fpadd` produces them.
- **Stale done:** `add_done` may still be high from the previous operation. It is never sampled in ISSUE, and is only sampled in WAIT.
- **Late done after timeout:** a late `add_done` from a timed-out operation is ignored. The next ISSUE restarts `fpadd`.

## Timing
- `in_ready` and `out_valid` are combinational from the state register only. No combinational path runs from `in_valid` or `out_ready` to any output.
- Element accepted in NEXT at cycle k:
  - ISSUE at k+1.
  - `fpadd` drives `done=0` from k+2.
  - WAIT runs from k+2.
- WAIT sees `add_done` at cycle d. At d+1 the block is in NEXT (`in_ready=1`) or OUT (`out_valid=1`).
- Single-element packet: accepted at k, `out_valid=1` at k+1.
- Reset during any state, including WAIT: the next cycle is FIRST with all outputs at their reset values. Any partial packet is discarded.
- `add_start` is never high in two consecutive cycles. It is never high in FIRST, NEXT, WAIT or OUT.

## Test plan
- **Single-element packet:** `0x40490FDB` with `in_last=1` -> `out_sum=0x40490FDB`, `out_count=1`, `out_timeout=0`, and `add_start` never asserted.
- **Three-element packet:** `0x3F800000`, `0x40000000`, `0x40400000` (1.0, 2.0, 3.0) against a real `fpadd` -> `out_sum=0x40C00000`, `out_count=3`.
  - `add_start` pulses exactly twice.
  - `add_a`/`add_b` equal (`0x3F800000`, `0x40000000`) for the first add, then (`0x40400000`, `0x40400000`) for the second.
- **Cancellation:** `0x3F800000`, `0xBF800000` -> `out_sum=0x00000000`, `out_count=2`.
- **Stale done and timeout:** stub holds `add_done=1` permanently, with `TIMEOUT=16` -> the WAIT capture occurs at ISSUE+1 with `acc=add_sum`.
  - Second run: stub holds `add_done=0`.
  - `out_timeout=1` exactly 16 WAIT cycles after ISSUE, with `out_sum` equal to the first element.
  - The next packet shows `out_timeout=0`.
- **Backpressure:** hold `out_ready=0` for 5 cycles with `out_valid=1` -> `out_sum`/`out_count` remain stable, `in_ready=0`, and the result is taken once on the first `out_ready=1`. FIRST follows on the next cycle.
- **Reset mid-WAIT:** assert `reset` for 1 cycle during WAIT -> next cycle shows `add_start=0`, `out_valid=0`, `busy=0`, `in_ready=1`.
  - A fresh packet of 2.0 + 2.0 then yields `out_sum=0x40800000`, `out_count=2`.
